breakout_block_column: RTL
==========================

Name: breakout_block_column

Overview:
- Parametrised successor to the fixed 8-row, single-hit block column in the breakout playfield.
- Holds NUM_ROWS stacked blocks in one x-column; each block takes HITS_TO_BREAK hits to destroy.
- Detects ball/face collisions through a 2-stage registered pipeline and issues one-cycle bounce pulses to the ball controller.
- Per collision event, exactly one hit is counted, enforced by a contact-hold FSM. Also accumulates a saturating column score and reports the column-cleared condition.

Parameters:
NUM_ROWS, 8, number of blocks in the column (1..16)
X_LEFT, 11, left x of block body, inclusive
X_RIGHT, 26, right x of block body, inclusive
Y_TOP0, 4, top y of row 0, inclusive
ROW_H, 73, block height in pixels; row r spans Y_TOP0+r*ROW_PITCH .. +ROW_H-1
ROW_PITCH, 74, y distance between row tops
EDGE, 3, face contact band depth in pixels
HITS_TO_BREAK, 1, hits needed to destroy a block (1..3)
POINTS, 7, score added per destroyed block
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
pix_x  in  11  current pixel x
pix_y  in  11  current pixel y
ball_x_l  in  11  ball left x
ball_x_r  in  11  ball right x
ball_y_t  in  11  ball top y
ball_y_b  in  11  ball bottom y
col_on  out  1  pixel lies inside a live block
col_shade  out  2  remaining hits of the block under the pixel, 0 if none
move_u  out  1  bounce-up pulse
move_d  out  1  bounce-down pulse
move_l  out  1  bounce-left pulse
move_r  out  1  bounce-right pulse
score  out  SCORE_W  column score
blocks_left  out  5  live block count
col_clear  out  1  sticky: all blocks destroyed

Behaviour:
- Reset (reset==0 at posedge):
  - every block hit count = HITS_TO_BREAK
  - score = 0, blocks_left = NUM_ROWS, col_clear = 0
  - move_* = 0, FSM = IDLE, pipeline valid = 0
- Reset dominates any concurrent hit. A mid-HOLD reset returns to IDLE with all blocks restored.
- Geometry: row r top T = Y_TOP0 + r*ROW_PITCH, bottom B = T + ROW_H - 1. Vertical overlap: ball_y_b>=T && ball_y_t<=B. Horizontal overlap: ball_x_r>=X_LEFT && ball_x_l<=X_RIGHT.
- Face conditions (live block only):
  - R: ball_x_l in [X_RIGHT-EDGE, X_RIGHT] with vertical overlap
  - L: ball_x_r in [X_LEFT, X_LEFT+EDGE] with vertical overlap
  - D: ball_y_t in [B-EDGE, B] with horizontal overlap
  - U: ball_y_b in [T, T+EDGE] with horizontal overlap
- A corner contact may assert one vertical and one horizontal face together; both pulses issue.
- Stage 1 (registered): lowest-index contacting live row → hit_row, face bits, s1_valid. Multi-row contact: lowest index wins; others ignored this event.
- Stage 2 FSM:
  - IDLE: on s1_valid, decrement that block's count, pulse the asserted move_* for exactly one cycle, latch hold_row, go HOLD.
  - HOLD: no decrements, no pulses. Return to IDLE on the first stage-1 sample with no contact on hold_row, whether that block is live or just destroyed.
  - Move pulses appear 2 clocks after the ball inputs that caused them.
- Destruction (count reaches 0), same cycle as the decrement:
  - block dies: col_on/col_shade drop for that row next cycle
  - score += POINTS, saturating at 2^SCORE_W-1 (no wrap)
  - blocks_left -= 1
  - when blocks_left reaches 0, col_clear sets, held until reset
- Partial hit (count stays >0): no score change, shade decrements.
- col_on/col_shade are combinational from pix_x/pix_y and block state. Pixel ranges are inclusive on both x and y.
- Ball coordinates beyond the last row bottom never match any row.

Test Plan:
- Reset, then sweep pix over (11..26, 4..76) and (11..26, 77) → col_on=1 inside, 0 at y=77; col_shade=1; score=0; blocks_left=8.
- Ball_x_l=25, y_t=100, y_b=107 held 5 cycles → move_r high exactly once, 2 clocks after first sample. Row1 dead, score=7, blocks_left=7, no further pulses while held.
- HITS_TO_BREAK=2: bottom-face contact on row0 (ball_y_t=75, x 12..19), then clear, then contact again → first pulse leaves shade=1 and score=0; second pulse destroys the block, score=7.
- Ball spanning rows 2 and 3 top/bottom faces simultaneously → only row2 is hit; row3 is untouched.
- Destroy all 8 blocks → score=56, blocks_left=0, col_clear=1. With SCORE_W=5 the score saturates at 31.
- Assert reset during HOLD with 3 blocks destroyed → next cycle all blocks live, score=0, FSM IDLE, move_*=0.

Source files
------------

// File: rtl/breakout_block_column.sv
// Breakout playfield block column: NUM_ROWS stacked multi-hit blocks in one x-column.
// A registered contact stage feeds a contact-hold FSM that turns each collision event
// into exactly one hit and one set of one-cycle bounce pulses.
module breakout_block_column #(
   parameter int unsigned NUM_ROWS      = 8,
   parameter int unsigned X_LEFT        = 11,
   parameter int unsigned X_RIGHT       = 26,
   parameter int unsigned Y_TOP0        = 4,
   parameter int unsigned ROW_H         = 73,
   parameter int unsigned ROW_PITCH     = 74,
   parameter int unsigned EDGE          = 3,
   parameter int unsigned HITS_TO_BREAK = 1,
   parameter int unsigned POINTS        = 7,
   parameter int unsigned SCORE_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [10:0]        pix_x,
   input  logic [10:0]        pix_y,
   input  logic [10:0]        ball_x_l,
   input  logic [10:0]        ball_x_r,
   input  logic [10:0]        ball_y_t,
   input  logic [10:0]        ball_y_b,
   output logic               col_on,
   output logic [1:0]         col_shade,
   output logic               move_u,
   output logic               move_d,
   output logic               move_l,
   output logic               move_r,
   output logic [SCORE_W-1:0] score,
   output logic [4:0]         blocks_left,
   output logic               col_clear
);

   // Row state is kept for the full 16-row index space so a 4-bit row index never
   // needs truncating; rows at or above NUM_ROWS stay permanently dead.
   localparam int unsigned MaxRows  = 16;
   localparam int unsigned XrInner  = X_RIGHT - EDGE;
   localparam int unsigned XlInner  = X_LEFT + EDGE;
   localparam int unsigned ScoreMax = (2 ** SCORE_W) - 1;

   typedef enum logic {StIdle, StHold} state_e;

   function automatic logic [31:0] row_top(input int unsigned r);
      return Y_TOP0 + r * ROW_PITCH;
   endfunction

   function automatic logic [31:0] row_bot(input int unsigned r);
      return Y_TOP0 + r * ROW_PITCH + ROW_H - 1;
   endfunction

   // Coordinates widened once so all geometry compares are plain 32-bit unsigned.
   logic [31:0] bxl, bxr, byt, byb, px, py;
   assign bxl = {21'd0, ball_x_l};
   assign bxr = {21'd0, ball_x_r};
   assign byt = {21'd0, ball_y_t};
   assign byb = {21'd0, ball_y_b};
   assign px  = {21'd0, pix_x};
   assign py  = {21'd0, pix_y};

   logic [1:0]          hits_q [MaxRows];
   logic [NUM_ROWS-1:0] live;
   logic [NUM_ROWS-1:0] v_ovl, face_u, face_d, face_l, face_r, touch;
   logic                h_ovl;

   logic                s1_valid_d, s1_valid_q;
   logic [3:0]          s1_row_d, s1_row_q;
   logic [3:0]          s1_face_d, s1_face_q;
   logic [MaxRows-1:0]  s1_vec_q;

   state_e              state_d, state_q;
   logic [3:0]          hold_row_d, hold_row_q;
   logic [3:0]          pulse_d, pulse_q;
   logic                hit_en, destroy;
   logic [1:0]          hit_cur;

   logic [31:0]         score_sum;
   logic [SCORE_W-1:0]  score_d, score_q;
   logic [4:0]          left_d, left_q;
   logic                clear_d, clear_q;

   // Liveness of each real row.
   always_comb begin
      live = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         live[r] = (hits_q[r] != 2'd0);
      end
   end

   assign h_ovl = (bxr >= X_LEFT) && (bxl <= X_RIGHT);

   // Face contact per live row.
   always_comb begin
      v_ovl  = '0;
      face_u = '0;
      face_d = '0;
      face_l = '0;
      face_r = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         v_ovl[r]  = (byb >= row_top(r)) && (byt <= row_bot(r));
         face_r[r] = live[r] && v_ovl[r] && (bxl >= XrInner) && (bxl <= X_RIGHT);
         face_l[r] = live[r] && v_ovl[r] && (bxr >= X_LEFT) && (bxr <= XlInner);
         face_d[r] = live[r] && h_ovl && (byt >= row_bot(r) - EDGE) && (byt <= row_bot(r));
         face_u[r] = live[r] && h_ovl && (byb >= row_top(r)) && (byb <= row_top(r) + EDGE);
      end
   end

   assign touch = face_u | face_d | face_l | face_r;

   // Lowest-index contacting row wins; other contacts are ignored for this event.
   always_comb begin
      s1_valid_d = 1'b0;
      s1_row_d   = '0;
      s1_face_d  = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         if (!s1_valid_d && touch[r]) begin
            s1_valid_d = 1'b1;
            s1_row_d   = 4'(r);
            s1_face_d  = {face_u[r], face_d[r], face_l[r], face_r[r]};
         end
      end
   end

   // Stage 1 contact register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_row_q   <= '0;
         s1_face_q  <= '0;
         s1_vec_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_row_q   <= s1_row_d;
         s1_face_q  <= s1_face_d;
         s1_vec_q   <= MaxRows'(touch);
      end
   end

   assign hit_cur = hits_q[s1_row_q];

   // Contact-hold FSM: one hit per event, held until the held row reports no contact.
   always_comb begin
      state_d    = state_q;
      hold_row_d = hold_row_q;
      pulse_d    = '0;
      hit_en     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s1_valid_q) begin
               hit_en     = 1'b1;
               pulse_d    = s1_face_q;
               hold_row_d = s1_row_q;
               state_d    = StHold;
            end
         end
         StHold: begin
            if (!s1_vec_q[hold_row_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign destroy = hit_en && (hit_cur == 2'd1);

   // Score, live count and sticky clear update on a destroying hit.
   always_comb begin
      score_sum = 32'(score_q) + POINTS;
      score_d   = score_q;
      left_d    = left_q;
      clear_d   = clear_q;
      if (destroy) begin
         score_d = (score_sum > ScoreMax) ? SCORE_W'(ScoreMax) : score_sum[SCORE_W-1:0];
         left_d  = left_q - 5'd1;
         if (left_q == 5'd1) begin
            clear_d = 1'b1;
         end
      end
   end

   // FSM, block counts and column totals; reset overrides any concurrent hit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         hold_row_q <= '0;
         pulse_q    <= '0;
         score_q    <= '0;
         left_q     <= 5'(NUM_ROWS);
         clear_q    <= 1'b0;
         for (int unsigned r = 0; r < MaxRows; r++) begin
            hits_q[r] <= (r < NUM_ROWS) ? 2'(HITS_TO_BREAK) : 2'd0;
         end
      end else begin
         state_q    <= state_d;
         hold_row_q <= hold_row_d;
         pulse_q    <= pulse_d;
         score_q    <= score_d;
         left_q     <= left_d;
         clear_q    <= clear_d;
         if (hit_en && (hit_cur != 2'd0)) begin
            hits_q[s1_row_q] <= hit_cur - 2'd1;
         end
      end
   end

   // Pixel lookup against live blocks, inclusive on both axes.
   always_comb begin
      col_on    = 1'b0;
      col_shade = 2'd0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         if (live[r] && (px >= X_LEFT) && (px <= X_RIGHT) &&
             (py >= row_top(r)) && (py <= row_bot(r))) begin
            col_on    = 1'b1;
            col_shade = hits_q[r];
         end
      end
   end

   assign move_u      = pulse_q[3];
   assign move_d      = pulse_q[2];
   assign move_l      = pulse_q[1];
   assign move_r      = pulse_q[0];
   assign score       = score_q;
   assign blocks_left = left_q;
   assign col_clear   = clear_q;

endmodule
